// File: rtl/mem_port_arbiter.sv
// Shares the single external memory port between icache (id 0) and dcache (id 1):
// round-robin request grant, grant lock across write-data bursts, tag-MSB response routing.
module mem_port_arbiter #(
  parameter int unsigned ADDR_BITS  = 28,
  parameter int unsigned DATA_BITS  = 128,
  parameter int unsigned TAG_BITS   = 5,
  parameter int unsigned DATA_BEATS = 4
) (
  input  logic                    clk,
  input  logic                    reset,

  input  logic                    ic_req_valid,
  output logic                    ic_req_ready,
  input  logic                    ic_req_rw,
  input  logic [ADDR_BITS-1:0]    ic_req_addr,
  input  logic [TAG_BITS-2:0]     ic_req_tag,
  input  logic                    ic_req_data_valid,
  output logic                    ic_req_data_ready,
  input  logic [DATA_BITS-1:0]    ic_req_data_bits,
  input  logic [DATA_BITS/8-1:0]  ic_req_data_mask,
  output logic                    ic_resp_valid,
  output logic [TAG_BITS-2:0]     ic_resp_tag,
  output logic [DATA_BITS-1:0]    ic_resp_data,

  input  logic                    dc_req_valid,
  output logic                    dc_req_ready,
  input  logic                    dc_req_rw,
  input  logic [ADDR_BITS-1:0]    dc_req_addr,
  input  logic [TAG_BITS-2:0]     dc_req_tag,
  input  logic                    dc_req_data_valid,
  output logic                    dc_req_data_ready,
  input  logic [DATA_BITS-1:0]    dc_req_data_bits,
  input  logic [DATA_BITS/8-1:0]  dc_req_data_mask,
  output logic                    dc_resp_valid,
  output logic [TAG_BITS-2:0]     dc_resp_tag,
  output logic [DATA_BITS-1:0]    dc_resp_data,

  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic                    mem_req_rw,
  output logic [ADDR_BITS-1:0]    mem_req_addr,
  output logic [TAG_BITS-1:0]     mem_req_tag,
  output logic                    mem_req_data_valid,
  input  logic                    mem_req_data_ready,
  output logic [DATA_BITS-1:0]    mem_req_data_bits,
  output logic [DATA_BITS/8-1:0]  mem_req_data_mask,
  input  logic                    mem_resp_valid,
  input  logic [TAG_BITS-1:0]     mem_resp_tag,
  input  logic [DATA_BITS-1:0]    mem_resp_data
);

  localparam int unsigned CNT_BITS = $clog2(DATA_BEATS) + 1;

  typedef enum logic [1:0] {IDLE, HOLD, WLOCK} state_t;

  state_t              state;
  logic                hold_id;
  logic                lock_id;
  logic                last_id;
  logic [CNT_BITS-1:0] beat_cnt;

  logic chosen_id, sel_id, sel_valid, sel_rw, own_id;
  logic req_open, data_open, req_fire, data_fire, last_beat;

  // Grant selection and request/data channel muxing
  always_comb begin
    chosen_id = 1'b0;
    if (ic_req_valid && dc_req_valid) chosen_id = ~last_id;
    else if (dc_req_valid)            chosen_id = 1'b1;

    sel_id    = (state == HOLD) ? hold_id : chosen_id;
    sel_valid = sel_id ? dc_req_valid : ic_req_valid;
    sel_rw    = sel_id ? dc_req_rw    : ic_req_rw;

    req_open      = reset && (state != WLOCK);
    mem_req_valid = req_open && sel_valid;
    mem_req_rw    = sel_rw;
    mem_req_addr  = sel_id ? dc_req_addr : ic_req_addr;
    mem_req_tag   = {sel_id, sel_id ? dc_req_tag : ic_req_tag};
    ic_req_ready  = req_open && mem_req_ready && !sel_id;
    dc_req_ready  = req_open && mem_req_ready &&  sel_id;

    // Before the lock, a beat may only move in the cycle its write request is accepted
    own_id    = (state == WLOCK) ? lock_id : sel_id;
    data_open = reset && ((state == WLOCK) || (mem_req_valid && sel_rw && mem_req_ready));

    mem_req_data_valid = data_open && (own_id ? dc_req_data_valid : ic_req_data_valid);
    mem_req_data_bits  = own_id ? dc_req_data_bits : ic_req_data_bits;
    mem_req_data_mask  = own_id ? dc_req_data_mask : ic_req_data_mask;
    ic_req_data_ready  = data_open && mem_req_data_ready && !own_id;
    dc_req_data_ready  = data_open && mem_req_data_ready &&  own_id;

    req_fire  = mem_req_valid && mem_req_ready;
    data_fire = mem_req_data_valid && mem_req_data_ready;
    last_beat = (state == WLOCK) ? (beat_cnt == CNT_BITS'(DATA_BEATS - 1))
                                 : (DATA_BEATS == 1);
  end

  // Response routing by requester id in the tag MSB
  always_comb begin
    ic_resp_valid = mem_resp_valid && !mem_resp_tag[TAG_BITS-1];
    dc_resp_valid = mem_resp_valid &&  mem_resp_tag[TAG_BITS-1];
    ic_resp_tag   = mem_resp_tag[TAG_BITS-2:0];
    dc_resp_tag   = mem_resp_tag[TAG_BITS-2:0];
    ic_resp_data  = mem_resp_data;
    dc_resp_data  = mem_resp_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      last_id  <= 1'b1;
      hold_id  <= 1'b0;
      lock_id  <= 1'b0;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE, HOLD: begin
          if (req_fire) begin
            last_id <= sel_id;
            if (sel_rw && !(data_fire && last_beat)) begin
              state    <= WLOCK;
              lock_id  <= sel_id;
              beat_cnt <= data_fire ? CNT_BITS'(1) : '0;
            end else begin
              state    <= IDLE;
              beat_cnt <= '0;
            end
          end else if (mem_req_valid) begin
            state   <= HOLD;
            hold_id <= sel_id;
          end else begin
            state <= IDLE;
          end
        end
        WLOCK: begin
          if (data_fire) begin
            if (last_beat) begin
              state    <= IDLE;
              beat_cnt <= '0;
            end else begin
              beat_cnt <= beat_cnt + CNT_BITS'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: arbitration order, backpressure, write lock,
// same-cycle write data, reset mid-burst and response routing.
module tb_mem_port_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic         ic_req_valid, ic_req_ready, ic_req_rw;
  logic [27:0]  ic_req_addr;
  logic [3:0]   ic_req_tag;
  logic         ic_req_data_valid, ic_req_data_ready;
  logic [127:0] ic_req_data_bits;
  logic [15:0]  ic_req_data_mask;
  logic         ic_resp_valid;
  logic [3:0]   ic_resp_tag;
  logic [127:0] ic_resp_data;
  logic         dc_req_valid, dc_req_ready, dc_req_rw;
  logic [27:0]  dc_req_addr;
  logic [3:0]   dc_req_tag;
  logic         dc_req_data_valid, dc_req_data_ready;
  logic [127:0] dc_req_data_bits;
  logic [15:0]  dc_req_data_mask;
  logic         dc_resp_valid;
  logic [3:0]   dc_resp_tag;
  logic [127:0] dc_resp_data;
  logic         mem_req_valid, mem_req_ready, mem_req_rw;
  logic [27:0]  mem_req_addr;
  logic [4:0]   mem_req_tag;
  logic         mem_req_data_valid, mem_req_data_ready;
  logic [127:0] mem_req_data_bits;
  logic [15:0]  mem_req_data_mask;
  logic         mem_resp_valid;
  logic [4:0]   mem_resp_tag;
  logic [127:0] mem_resp_data;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter dut (
    .clk(clk), .reset(reset),
    .ic_req_valid(ic_req_valid), .ic_req_ready(ic_req_ready), .ic_req_rw(ic_req_rw),
    .ic_req_addr(ic_req_addr), .ic_req_tag(ic_req_tag),
    .ic_req_data_valid(ic_req_data_valid), .ic_req_data_ready(ic_req_data_ready),
    .ic_req_data_bits(ic_req_data_bits), .ic_req_data_mask(ic_req_data_mask),
    .ic_resp_valid(ic_resp_valid), .ic_resp_tag(ic_resp_tag), .ic_resp_data(ic_resp_data),
    .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_req_rw(dc_req_rw),
    .dc_req_addr(dc_req_addr), .dc_req_tag(dc_req_tag),
    .dc_req_data_valid(dc_req_data_valid), .dc_req_data_ready(dc_req_data_ready),
    .dc_req_data_bits(dc_req_data_bits), .dc_req_data_mask(dc_req_data_mask),
    .dc_resp_valid(dc_resp_valid), .dc_resp_tag(dc_resp_tag), .dc_resp_data(dc_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rw(mem_req_rw),
    .mem_req_addr(mem_req_addr), .mem_req_tag(mem_req_tag),
    .mem_req_data_valid(mem_req_data_valid), .mem_req_data_ready(mem_req_data_ready),
    .mem_req_data_bits(mem_req_data_bits), .mem_req_data_mask(mem_req_data_mask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_tag(mem_resp_tag), .mem_resp_data(mem_resp_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs are then driven 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int hs;
  logic [5:0] dr_pat;

  initial begin
    ic_req_valid = 0; ic_req_rw = 0; ic_req_addr = '0; ic_req_tag = '0;
    ic_req_data_valid = 0; ic_req_data_bits = '0; ic_req_data_mask = '0;
    dc_req_valid = 0; dc_req_rw = 0; dc_req_addr = '0; dc_req_tag = '0;
    dc_req_data_valid = 0; dc_req_data_bits = '0; dc_req_data_mask = '0;
    mem_req_ready = 1; mem_req_data_ready = 0;
    mem_resp_valid = 0; mem_resp_tag = '0; mem_resp_data = '0;
    reset = 0;

    // In reset: requests blocked, responses still routed
    ic_req_valid = 1; ic_req_addr = 28'h0000123; ic_req_tag = 4'd3;
    tick(); tick();
    mem_resp_valid = 1; mem_resp_tag = 5'b10010; mem_resp_data = 128'hDEAD;
    #1;
    chk("rst_mem_req_valid", 128'(mem_req_valid), 128'd0);
    chk("rst_ic_req_ready", 128'(ic_req_ready), 128'd0);
    chk("rst_dc_resp_valid", 128'(dc_resp_valid), 128'd1);
    chk("rst_dc_resp_tag", 128'(dc_resp_tag), 128'd2);
    chk("rst_ic_resp_valid", 128'(ic_resp_valid), 128'd0);
    mem_resp_valid = 0;
    reset = 1;

    // Tie after reset: ic, dc, ic, dc
    dc_req_valid = 1; dc_req_addr = 28'h0000456; dc_req_tag = 4'd4;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("tie_valid", 128'(mem_req_valid), 128'd1);
      chk("tie_id", 128'(mem_req_tag[4]), 128'(i % 2));
      chk("tie_ic_ready", 128'(ic_req_ready), 128'(i % 2 == 0));
      chk("tie_dc_ready", 128'(dc_req_ready), 128'(i % 2 == 1));
      tick();
    end
    dc_req_valid = 0;

    // Lone icache read plus response routing
    #1;
    chk("lone_valid", 128'(mem_req_valid), 128'd1);
    chk("lone_tag", 128'(mem_req_tag), 128'h03);
    chk("lone_addr", 128'(mem_req_addr), 128'h123);
    chk("lone_ic_ready", 128'(ic_req_ready), 128'd1);
    chk("lone_dc_ready", 128'(dc_req_ready), 128'd0);
    mem_resp_valid = 1; mem_resp_tag = 5'b00011; mem_resp_data = 128'h0123_4567_89AB_CDEF;
    #1;
    chk("resp_ic_valid", 128'(ic_resp_valid), 128'd1);
    chk("resp_ic_tag", 128'(ic_resp_tag), 128'd3);
    chk("resp_dc_valid", 128'(dc_resp_valid), 128'd0);
    chk("resp_dc_data", dc_resp_data, 128'h0123_4567_89AB_CDEF);
    tick();
    ic_req_valid = 0; mem_resp_valid = 0;

    // Backpressure: dcache held 4 cycles while icache arrives in cycle 2
    dc_req_valid = 1; dc_req_addr = 28'h0ABCDEF; dc_req_tag = 4'hA; mem_req_ready = 0;
    for (int c = 1; c <= 4; c++) begin
      if (c == 2) begin
        ic_req_valid = 1; ic_req_addr = 28'h0000111; ic_req_tag = 4'd1;
      end
      if (c == 4) mem_req_ready = 1;
      #1;
      chk("bp_tag", 128'(mem_req_tag), 128'h1A);
      chk("bp_addr", 128'(mem_req_addr), 128'h0ABCDEF);
      chk("bp_ic_ready", 128'(ic_req_ready), 128'd0);
      chk("bp_dc_ready", 128'(dc_req_ready), 128'(c == 4));
      tick();
    end
    dc_req_valid = 0;
    #1;
    chk("bp_next_tag", 128'(mem_req_tag), 128'h01);
    chk("bp_next_ic_ready", 128'(ic_req_ready), 128'd1);
    tick();

    // Write lock: dcache write, icache read waiting, data_ready 1,0,1,1,0,1
    dc_req_valid = 1; dc_req_rw = 1; dc_req_addr = 28'h0000200; dc_req_tag = 4'd5;
    #1;
    chk("wl_accept_tag", 128'(mem_req_tag), 128'h15);
    chk("wl_accept_rw", 128'(mem_req_rw), 128'd1);
    chk("wl_dc_ready", 128'(dc_req_ready), 128'd1);
    chk("wl_ic_ready", 128'(ic_req_ready), 128'd0);
    tick();
    dc_req_valid = 0; dc_req_rw = 0;
    dc_req_data_valid = 1; dc_req_data_mask = 16'hF0F0;
    ic_req_data_valid = 1; ic_req_data_bits = 128'hBAD;
    dr_pat = 6'b101101;
    hs = 0;
    for (int i = 0; i < 6; i++) begin
      mem_req_data_ready = dr_pat[i];
      dc_req_data_bits = 128'(hs + 100);
      #1;
      chk("wl_mem_req_valid", 128'(mem_req_valid), 128'd0);
      chk("wl_ic_req_ready", 128'(ic_req_ready), 128'd0);
      chk("wl_ic_data_ready", 128'(ic_req_data_ready), 128'd0);
      chk("wl_dc_data_ready", 128'(dc_req_data_ready), 128'(dr_pat[i]));
      chk("wl_data_bits", mem_req_data_bits, 128'(hs + 100));
      chk("wl_data_mask", 128'(mem_req_data_mask), 128'hF0F0);
      if (dr_pat[i]) hs++;
      tick();
    end
    dc_req_data_valid = 0; ic_req_data_valid = 0; mem_req_data_ready = 0;
    #1;
    chk("wl_release_valid", 128'(mem_req_valid), 128'd1);
    chk("wl_release_ic_ready", 128'(ic_req_ready), 128'd1);
    tick();

    // Same-cycle data: first beat counted, lock releases after 3 more
    dc_req_valid = 1; dc_req_rw = 1; dc_req_tag = 4'd6;
    dc_req_data_valid = 1; dc_req_data_bits = 128'd1; mem_req_data_ready = 1;
    #1;
    chk("sc_dc_ready", 128'(dc_req_ready), 128'd1);
    chk("sc_dc_data_ready", 128'(dc_req_data_ready), 128'd1);
    chk("sc_mem_data_valid", 128'(mem_req_data_valid), 128'd1);
    tick();
    dc_req_valid = 0; dc_req_rw = 0;
    for (int b = 0; b < 3; b++) begin
      #1;
      chk("sc_locked_valid", 128'(mem_req_valid), 128'd0);
      chk("sc_locked_ic_ready", 128'(ic_req_ready), 128'd0);
      tick();
    end
    dc_req_data_valid = 0; mem_req_data_ready = 0;
    #1;
    chk("sc_release_ic_ready", 128'(ic_req_ready), 128'd1);
    tick();

    // Reset mid-write after beat 2 of 4
    ic_req_rw = 1; ic_req_addr = 28'h0000300; ic_req_tag = 4'd7;
    #1;
    chk("rw_accept_ic_ready", 128'(ic_req_ready), 128'd1);
    tick();
    ic_req_valid = 0; ic_req_rw = 0;
    ic_req_data_valid = 1; mem_req_data_ready = 1;
    for (int b = 0; b < 2; b++) begin
      #1;
      chk("rw_beat_ready", 128'(ic_req_data_ready), 128'd1);
      tick();
    end
    reset = 0; dc_req_valid = 1;
    #1;
    chk("rw_rst_data_ready", 128'(ic_req_data_ready), 128'd0);
    chk("rw_rst_data_valid", 128'(mem_req_data_valid), 128'd0);
    chk("rw_rst_req_valid", 128'(mem_req_valid), 128'd0);
    chk("rw_rst_dc_ready", 128'(dc_req_ready), 128'd0);
    tick();
    reset = 1; dc_req_valid = 0; ic_req_data_valid = 0; mem_req_data_ready = 0;
    ic_req_valid = 1; ic_req_addr = 28'h0000400; ic_req_tag = 4'd2;
    #1;
    chk("rw_after_valid", 128'(mem_req_valid), 128'd1);
    chk("rw_after_rw", 128'(mem_req_rw), 128'd0);
    chk("rw_after_ic_ready", 128'(ic_req_ready), 128'd1);
    tick();
    ic_req_valid = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
